sobel_filter: RTL and testbench

Streaming 3x3 Sobel edge detector for 8-bit greyscale images held in a 32-bit-wide input block RAM, four pixels per word.
- Started by a one-cycle `start` pulse.
- Reads the whole image in raster order and computes the gradient magnitude per pixel.
- Writes packed results to an output block RAM at the same word addresses.
- Sits between the host-loaded input BRAM and the host-read output BRAM in the Zynq-7000 PL.

---
 rtl/sobel_pkg.sv | 19 +
 rtl/sobel_kernel.sv | 31 +++
 rtl/sobel_filter.sv | 189 ++++++++++++++++++
 tb/tb_sobel_filter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared mode encodings, FSM states and constants for the Sobel filter
package sobel_pkg;
  localparam logic [1:0] MODE_GX  = 2'b00;
  localparam logic [1:0] MODE_GY  = 2'b01;
  localparam logic [1:0] MODE_SUM = 2'b10;
  localparam logic [1:0] MODE_MAX = 2'b11;
  localparam int PIXELS_PER_WORD = 4;
  localparam int READ_LATENCY = 2;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_UNPACK,
    S_COMPUTE,
    S_WRITE,
    S_DONE
  } state_t;
endpackage

// File: rtl/sobel_kernel.sv
// sobel_kernel: combinational 3x3 Sobel gradient magnitude, saturated to one pixel
// Ports:
//   win  - 3x3 window, pixel (r,c) at slot r*3+c, row 0 is the upper row
//   mode - magnitude select (|Gx|, |Gy|, sum, max)
//   mag  - saturated magnitude
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic [9*PIXEL_WIDTH-1:0] win,
  input  logic [1:0]               mode,
  output logic [PIXEL_WIDTH-1:0]   mag
);
  localparam int AW = PIXEL_WIDTH + 4;
  logic [AW-1:0] e [9];
  logic signed [AW-1:0] gx, gy;
  logic [AW-1:0] ax, ay, sel;
  always_comb begin
    for (int i = 0; i < 9; i++) e[i] = AW'(win[i*PIXEL_WIDTH +: PIXEL_WIDTH]);
    gx = e[2] + (e[5] << 1) + e[8] - e[0] - (e[3] << 1) - e[6];
    gy = e[6] + (e[7] << 1) + e[8] - e[0] - (e[1] << 1) - e[2];
    ax = gx < 0 ? -gx : gx;
    ay = gy < 0 ? -gy : gy;
    sel = mode == MODE_GX  ? ax :
          mode == MODE_GY  ? ay :
          mode == MODE_SUM ? ax + ay :
          (ax > ay ? ax : ay);
    mag = sel > AW'({PIXEL_WIDTH{1'b1}}) ? '1 : sel[PIXEL_WIDTH-1:0];
  end
endmodule

// File: rtl/sobel_filter.sv
// sobel_filter: streaming 3x3 Sobel edge detector between an input and an output BRAM
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   start, mode              - frame request and magnitude select (sampled at start)
//   image_width_in/height_in - frame dimensions in pixels/rows (sampled at start)
//   busy, done               - frame in progress, one-cycle completion pulse
//   bram_in_*                - read port of the input image BRAM (2-cycle latency)
//   bram_out_*               - write port of the result BRAM, same packing/addresses
module sobel_filter
  import sobel_pkg::*;
#(
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int PIXEL_WIDTH     = 8,
  parameter int ADDR_WIDTH      = 10,
  parameter int IMG_WIDTH_BITS  = 16,
  parameter int IMG_HEIGHT_BITS = 16,
  parameter int IMG_WIDTH_MAX   = 64,
  parameter int IMG_HEIGHT_MAX  = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [IMG_WIDTH_BITS-1:0]  image_width_in,
  input  logic [IMG_HEIGHT_BITS-1:0] image_height_in,
  output logic                       busy,
  output logic                       done,
  output logic                       bram_in_ena,
  output logic [ADDR_WIDTH-1:0]      bram_in_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_in_dout,
  output logic                       bram_in_wea,
  output logic [BRAM_DATA_WIDTH-1:0] bram_in_dina,
  output logic                       bram_out_ena,
  output logic [ADDR_WIDTH-1:0]      bram_out_addr,
  output logic [BRAM_DATA_WIDTH-1:0] bram_out_dina,
  output logic                       bram_out_wea
);
  localparam int PPW = BRAM_DATA_WIDTH / PIXEL_WIDTH;
  localparam int LPW = $clog2(PPW);
  localparam int CW  = $clog2(IMG_WIDTH_MAX);
  localparam int WW  = CW - LPW;
  localparam int RW  = $clog2(IMG_HEIGHT_MAX);
  state_t state, state_nx;
  logic [1:0] mode_q;
  logic [IMG_WIDTH_BITS-1:0] w_q;
  logic [IMG_HEIGHT_BITS-1:0] h_q;
  logic [WW-1:0] word, lw;
  logic [CW-1:0] lc;
  logic [RW-1:0] row, orow, lr;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic [1:0] top, mid, bot, lat_cnt;
  logic [BRAM_DATA_WIDTH-1:0] out_data, pix_out;
  logic [IMG_WIDTH_MAX*PIXEL_WIDTH-1:0] line_buf [3];
  logic [1:0] slot [3];
  logic dims_ok, row_end;
  always_comb begin
    dims_ok = w_q[LPW-1:0] == '0 &&
              w_q >= IMG_WIDTH_BITS'(3) && w_q <= IMG_WIDTH_BITS'(IMG_WIDTH_MAX) &&
              h_q >= IMG_HEIGHT_BITS'(3) && h_q <= IMG_HEIGHT_BITS'(IMG_HEIGHT_MAX);
    row_end = word == lw;
    slot = '{top, mid, bot};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  // Output row r-1 is produced right after input row r lands; the last row
  // (all border) is written once the input is exhausted.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      state_nx = start ? S_CHECK : S_IDLE;
      S_CHECK:     state_nx = dims_ok ? S_RD_ISSUE : S_DONE;
      S_RD_ISSUE:  state_nx = S_RD_WAIT;
      S_RD_WAIT:   state_nx = lat_cnt == 2'(READ_LATENCY - 2) ? S_RD_UNPACK : S_RD_WAIT;
      S_RD_UNPACK: state_nx = row_end && row != '0 ? S_COMPUTE : S_RD_ISSUE;
      S_COMPUTE:   state_nx = S_WRITE;
      S_WRITE:     state_nx = !row_end ? S_COMPUTE : orow == lr ? S_DONE : row == lr ? S_COMPUTE : S_RD_ISSUE;
      S_DONE:      state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    busy = state != S_IDLE && state != S_DONE;
    done = state == S_DONE;
    bram_in_ena = state == S_RD_ISSUE;
    bram_out_ena = state == S_WRITE;
    bram_out_wea = state == S_WRITE;
  end
  assign bram_in_addr = rd_addr;
  assign bram_in_wea = 1'b0;
  assign bram_in_dina = '0;
  assign bram_out_addr = wr_addr;
  assign bram_out_dina = out_data;
  // Row slots rotate so that top/mid/bot always hold rows r-2/r-1/r.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q <= '0;
      w_q <= '0;
      h_q <= '0;
      lw <= '0;
      lc <= '0;
      lr <= '0;
      row <= '0;
      orow <= '0;
      word <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
      top <= '0;
      mid <= '0;
      bot <= '0;
      lat_cnt <= '0;
      out_data <= '0;
    end else
      case (state)
        S_IDLE:
          if (start) begin
            mode_q <= mode;
            w_q <= image_width_in;
            h_q <= image_height_in;
            lw <= WW'((image_width_in >> LPW) - 1);
            lc <= CW'(image_width_in - 1);
            lr <= RW'(image_height_in - 1);
          end
        S_CHECK: begin
          row <= '0;
          orow <= '0;
          word <= '0;
          rd_addr <= '0;
          wr_addr <= '0;
          top <= 2'd0;
          mid <= 2'd1;
          bot <= 2'd2;
        end
        S_RD_ISSUE: lat_cnt <= '0;
        S_RD_WAIT: lat_cnt <= lat_cnt + 2'd1;
        S_RD_UNPACK: begin
          rd_addr <= rd_addr + ADDR_WIDTH'(1);
          word <= row_end ? '0 : word + WW'(1);
          if (row_end && row == '0) begin
            row <= RW'(1);
            top <= mid;
            mid <= bot;
            bot <= top;
          end
        end
        S_COMPUTE: out_data <= pix_out;
        S_WRITE: begin
          wr_addr <= wr_addr + ADDR_WIDTH'(1);
          word <= row_end ? '0 : word + WW'(1);
          if (row_end && orow != lr) begin
            orow <= orow + RW'(1);
            if (row != lr) begin
              row <= row + RW'(1);
              top <= mid;
              mid <= bot;
              bot <= top;
            end
          end
        end
        default: ;
      endcase
  always_ff @(posedge clk)
    if (state == S_RD_UNPACK) line_buf[bot][word*BRAM_DATA_WIDTH +: BRAM_DATA_WIDTH] <= bram_in_dout;
  // One kernel per pixel lane; neighbour columns wrap inside the buffer but
  // any wrapped window is on a border column and is forced to 0.
  for (genvar k = 0; k < PPW; k++) begin : g_lane
    logic [CW-1:0] c, ci;
    logic [9*PIXEL_WIDTH-1:0] win;
    logic [PIXEL_WIDTH-1:0] mag;
    logic border;
    always_comb begin
      c = {word, LPW'(k)};
      ci = '0;
      win = '0;
      border = orow == '0 || orow == lr || c == '0 || c == lc;
      for (int r = 0; r < 3; r++)
        for (int j = 0; j < 3; j++) begin
          ci = c + CW'(j) - CW'(1);
          win[(r*3+j)*PIXEL_WIDTH +: PIXEL_WIDTH] = line_buf[slot[r]][ci*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
    end
    sobel_kernel #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_kernel (
      .win(win),
      .mode(mode_q),
      .mag(mag)
    );
    assign pix_out[k*PIXEL_WIDTH +: PIXEL_WIDTH] = border ? '0 : mag;
  end
endmodule

// File: tb/tb_sobel_filter.sv
// tb_sobel_filter: directed self-checking bench for sobel_filter with BRAM models
module tb_sobel_filter;
  localparam int LIM = 20000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [15:0] iw = '0, ih = '0;
  logic busy, done, bram_in_ena, bram_in_wea, bram_out_ena, bram_out_wea;
  logic [9:0] bram_in_addr, bram_out_addr;
  logic [31:0] bram_in_dout, bram_in_dina, bram_out_dina;
  logic [31:0] imem [1024];
  logic [31:0] omem [1024];
  int wcnt [1024];
  logic [31:0] s1 = '0, dout = '0;
  logic clr = 1'b0;
  int total = 0, bad = 0;
  int in_reads = 0, out_writes = 0, order_err = 0, last_addr = -1;
  int cyc, wsave;
  logic busy_c1;
  sobel_filter dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .mode(mode),
    .image_width_in(iw),
    .image_height_in(ih),
    .busy(busy),
    .done(done),
    .bram_in_ena(bram_in_ena),
    .bram_in_addr(bram_in_addr),
    .bram_in_dout(bram_in_dout),
    .bram_in_wea(bram_in_wea),
    .bram_in_dina(bram_in_dina),
    .bram_out_ena(bram_out_ena),
    .bram_out_addr(bram_out_addr),
    .bram_out_dina(bram_out_dina),
    .bram_out_wea(bram_out_wea)
  );
  assign bram_in_dout = dout;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bram_in_ena) s1 <= imem[bram_in_addr];
    dout <= s1;
  end
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) begin
        omem[i] = '0;
        wcnt[i] = 0;
      end
      order_err = 0;
      last_addr = -1;
      in_reads = 0;
      out_writes = 0;
    end else begin
      if (bram_in_ena) in_reads++;
      if (bram_out_ena !== bram_out_wea) order_err++;
      if (bram_out_ena && bram_out_wea) begin
        if (int'(bram_out_addr) <= last_addr) order_err++;
        last_addr = int'(bram_out_addr);
        omem[bram_out_addr] = bram_out_dina;
        wcnt[bram_out_addr]++;
        out_writes++;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic load_grad(input int w, input int h);
    logic [31:0] v;
    for (int a = 0; a < w*h/4; a++) begin
      for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(4*((a*4+k) % w));
      imem[a] = v;
    end
  endtask
  task automatic load_step();
    logic [31:0] v;
    for (int a = 0; a < 1024; a++) begin
      for (int k = 0; k < 4; k++) v[k*8 +: 8] = (a*4+k)/64 >= 32 ? 8'hff : 8'h00;
      imem[a] = v;
    end
  endtask
  // kind 0: gradient (0x20 inside), 1: all zero, 2: vertical step (0xff on rows 31/32)
  function automatic logic [31:0] exp_word(input int kind, input int w, input int h, input int a);
    logic [31:0] v;
    int r, c;
    logic [7:0] b;
    v = '0;
    r = a / (w/4);
    for (int k = 0; k < 4; k++) begin
      c = (a % (w/4))*4 + k;
      b = kind == 0 ? 8'h20 : (kind == 2 && (r == 31 || r == 32)) ? 8'hff : 8'h00;
      if (r == 0 || r == h-1 || c == 0 || c == w-1) b = 8'h00;
      v[k*8 +: 8] = b;
    end
    return v;
  endfunction
  task automatic run_frame(input logic [1:0] m, input int w, input int h, input int poke);
    @(negedge clk);
    mode = m;
    iw = 16'(w);
    ih = 16'(h);
    start = 1'b1;
    clr = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      clr = 1'b0;
      start = cyc == poke;
      mode = ~m;
      iw = '0;
      ih = '0;
      if (cyc == 1) busy_c1 = busy;
    end while (!done && cyc < LIM);
    start = 1'b0;
    chk("done_seen", {31'b0, done}, 32'd1);
    chk("busy_at_done", {31'b0, busy}, 32'd0);
  endtask
  task automatic check_frame(input string tag, input int kind, input int w, input int h);
    int n, nb, nw;
    n = w*h/4;
    nb = 0;
    nw = 0;
    for (int a = 0; a < 1024; a++) begin
      if (a < n && omem[a] !== exp_word(kind, w, h, a)) nb++;
      if (wcnt[a] != (a < n ? 1 : 0)) nw++;
    end
    chk({tag, "_data"}, nb, 0);
    chk({tag, "_wr_once"}, nw, 0);
    chk({tag, "_order"}, order_err, 0);
    chk({tag, "_reads"}, {31'b0, in_reads >= n}, 32'd1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctl", {26'b0, busy, done, bram_in_ena, bram_in_wea, bram_out_ena, bram_out_wea}, 32'd0);
    chk("rst_addr", {12'b0, bram_in_addr, bram_out_addr}, 32'd0);
    chk("rst_dout", bram_out_dina, 32'd0);
    rst_n = 1'b1;
    load_grad(64, 64);
    run_frame(2'b10, 64, 64, 0);
    chk("g10_w0", omem[0], 32'h0);
    chk("g10_w15", omem[15], 32'h0);
    chk("g10_w16", omem[16], 32'h20202000);
    chk("g10_w17", omem[17], 32'h20202020);
    chk("g10_w31", omem[31], 32'h00202020);
    chk("g10_w1008", omem[1008], 32'h0);
    chk("g10_w1023", omem[1023], 32'h0);
    check_frame("g10", 0, 64, 64);
    run_frame(2'b01, 64, 64, 0);
    check_frame("g01", 1, 64, 64);
    run_frame(2'b00, 64, 64, 0);
    check_frame("g00", 0, 64, 64);
    run_frame(2'b10, 64, 64, 300);
    check_frame("poke", 0, 64, 64);
    run_frame(2'b10, 64, 64, 0);
    check_frame("b2b", 0, 64, 64);
    load_step();
    run_frame(2'b10, 64, 64, 0);
    chk("s10_w480", omem[480], 32'h0);
    chk("s10_w496", omem[496], 32'hffffff00);
    chk("s10_w517", omem[517], 32'hffffffff);
    chk("s10_w527", omem[527], 32'h00ffffff);
    chk("s10_w528", omem[528], 32'h0);
    check_frame("s10", 2, 64, 64);
    run_frame(2'b11, 64, 64, 0);
    check_frame("s11", 2, 64, 64);
    run_frame(2'b00, 64, 64, 0);
    check_frame("s00", 1, 64, 64);
    load_grad(8, 4);
    run_frame(2'b10, 8, 4, 0);
    chk("small_w2", omem[2], 32'h20202000);
    chk("small_w3", omem[3], 32'h00202020);
    check_frame("small", 0, 8, 4);
    run_frame(2'b10, 62, 64, 0);
    chk("inv_cyc", cyc, 2);
    chk("inv_busy_c1", {31'b0, busy_c1}, 32'd1);
    chk("inv_reads", in_reads, 0);
    chk("inv_writes", out_writes, 0);
    @(negedge clk);
    chk("inv_done_pulse", {31'b0, done}, 32'd0);
    load_grad(64, 64);
    mode = 2'b10;
    iw = 16'd64;
    ih = 16'd64;
    start = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr = 1'b0;
    repeat (1500) @(negedge clk);
    chk("mid_busy", {31'b0, busy}, 32'd1);
    chk("mid_writes", {31'b0, out_writes > 0}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", {26'b0, busy, done, bram_in_ena, bram_in_wea, bram_out_ena, bram_out_wea}, 32'd0);
    chk("abort_addr", {12'b0, bram_in_addr, bram_out_addr}, 32'd0);
    chk("abort_dout", bram_out_dina | bram_in_dina, 32'd0);
    wsave = out_writes;
    repeat (4) @(negedge clk);
    chk("abort_no_wr", out_writes, wsave);
    rst_n = 1'b1;
    run_frame(2'b10, 64, 64, 0);
    check_frame("after_rst", 0, 64, 64);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
